// File: rtl/ext_bus_pkg.sv
// Shared types and default parameters for the external bus controller.
// Holds the controller FSM states and the layout of one posted-write entry.
package ext_bus_pkg;

  localparam int          DEF_WBUF_DEPTH = 4;
  localparam int          DEF_TIMEOUT    = 15;
  localparam logic [31:0] DEF_ERR_DATA   = 32'hDEADBEEF;

  // Width of the ext_ack wait counter; covers the full 1..255 timeout range.
  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } bus_state_t;

  // One posted write: address in the upper half, data in the lower half.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Synchronous FIFO holding posted writes ({addr,wdata}, 64 bits per entry).
// Push is ignored when full, pop when empty; push and pop may share a cycle.
module wbuf_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [63:0] wr_data,
  input  logic        pop,
  output logic [63:0] rd_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the
  // pointers and count, so resetting it would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ext_bus_ctrl.sv
// CPU-to-external-bus bridge: posted writes through a small FIFO, blocking
// reads with a wait-limit that returns error data and sets a sticky flag.
module ext_bus_ctrl
  import ext_bus_pkg::*;
#(
  parameter int          WBUF_DEPTH = DEF_WBUF_DEPTH,
  parameter int          TIMEOUT    = DEF_TIMEOUT,
  parameter logic [31:0] ERR_DATA   = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_cs,
  input  logic        cpu_wr_rd,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdata,
  output logic        bus_err
);

  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(TIMEOUT);

  bus_state_t        state;
  bus_state_t        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       rd_addr;

  logic              wr_req;
  logic              rd_req;
  logic              busy;
  logic              timed_out;

  logic              wb_push;
  logic              wb_pop;
  logic              wb_full;
  logic              wb_empty;
  wbuf_entry_t       wb_in;
  logic [63:0]       wb_head_raw;
  wbuf_entry_t       wb_head;

  logic              rd_addr_load;
  logic              rdata_load;
  logic [31:0]       rdata_nxt;
  logic              err_set;

  assign wr_req = cpu_cs && cpu_wr_rd;
  assign rd_req = cpu_cs && !cpu_wr_rd;

  // A full buffer stalls the write even if the head pops this cycle.
  assign wb_push = wr_req && !wb_full;
  assign wb_in   = '{addr: cpu_addr, data: cpu_wdata};
  assign wb_head = wbuf_entry_t'(wb_head_raw);

  assign cpu_stall = (wr_req && wb_full) || (rd_req && state != RESP);

  assign busy      = (state == WRITE) || (state == READ);
  // An ack arriving on the limit cycle completes normally.
  assign timed_out = busy && !ext_ack && (wait_cnt == TMO);

  wbuf_fifo #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .push    (wb_push),
    .wr_data (wb_in),
    .pop     (wb_pop),
    .rd_data (wb_head_raw),
    .full    (wb_full),
    .empty   (wb_empty)
  );

  // External outputs derive only from state and stored data, never cpu_*.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    wb_pop       = 1'b0;
    rd_addr_load = 1'b0;
    rdata_load   = 1'b0;
    rdata_nxt    = ext_rdata;
    err_set      = 1'b0;
    ext_req      = 1'b0;
    ext_we       = 1'b0;
    ext_addr     = '0;
    ext_wdata    = '0;

    unique case (state)
      IDLE: begin
        if (!wb_empty) begin
          state_nxt = WRITE;
        end else if (rd_req) begin
          rd_addr_load = 1'b1;
          state_nxt    = READ;
        end
      end
      WRITE: begin
        ext_req   = 1'b1;
        ext_we    = 1'b1;
        ext_addr  = wb_head.addr;
        ext_wdata = wb_head.data;
        if (ext_ack || timed_out) begin
          wb_pop    = 1'b1;
          err_set   = timed_out;
          state_nxt = IDLE;
        end
      end
      READ: begin
        ext_req  = 1'b1;
        ext_addr = rd_addr;
        if (ext_ack) begin
          rdata_load = 1'b1;
          state_nxt  = RESP;
        end else if (timed_out) begin
          rdata_load = 1'b1;
          rdata_nxt  = ERR_DATA;
          err_set    = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rd_addr   <= '0;
      cpu_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      state <= state_nxt;

      // IDLE always precedes WRITE/READ, so holding zero there clears the
      // counter on entry; it saturates at the limit.
      if (!busy)
        wait_cnt <= '0;
      else if (!ext_ack && wait_cnt != TMO)
        wait_cnt <= wait_cnt + WAIT_W'(1);

      if (rd_addr_load) rd_addr   <= cpu_addr;
      if (rdata_load)   cpu_rdata <= rdata_nxt;
      if (err_set)      bus_err   <= 1'b1;
    end
  end

endmodule
